// File: rtl/sdu_hex_tx.sv
// -----------------------------------------------------------------------------
// sdu_hex_tx
//   Transmit half of the serial debug unit link. Takes one DATA_WIDTH word per
//   valid/ready handshake and prints it on an 8N1 UART line as uppercase ASCII
//   hex, most significant nibble first, optionally followed by CR LF.
//
// Parameters
//   DATA_WIDTH    width of word_data (multiple of 4)
//   CLKS_PER_BIT  cpu_clk cycles per UART bit (>= 2)
//
// Ports
//   cpu_clk     in   system clock, all logic on the rising edge
//   cpu_rst     in   synchronous active-high reset
//   word_valid  in   source has a word to send
//   word_ready  out  block accepts a word this cycle (only in IDLE)
//   word_data   in   word to print
//   word_eol    in   append 0x0D 0x0A after the hex digits
//   txd         out  UART serial output, idle high
//   busy        out  inverse of word_ready
// -----------------------------------------------------------------------------
module sdu_hex_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic [DATA_WIDTH-1:0] word_data,
    input  logic                  word_eol,
    output logic                  txd,
    output logic                  busy
);

    localparam int NIBBLES   = DATA_WIDTH / 4;
    localparam int MAX_CHARS = NIBBLES + 2;
    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int CHAR_W    = $clog2(MAX_CHARS);
    localparam int NIB_SLOTS = 2 ** CHAR_W;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CHAR_W-1:0] IDX_CR     = CHAR_W'(NIBBLES);
    localparam logic [CHAR_W-1:0] IDX_LAST_H = CHAR_W'(NIBBLES - 1);
    localparam logic [CHAR_W-1:0] IDX_LAST_E = CHAR_W'(NIBBLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q,      state_d;
    logic [CNT_W-1:0]       bit_cnt_q,    bit_cnt_d;
    logic [2:0]             bit_idx_q,    bit_idx_d;
    logic [CHAR_W-1:0]      char_idx_q,   char_idx_d;
    logic [DATA_WIDTH-1:0]  data_q,       data_d;
    logic                   eol_q,        eol_d;
    logic                   txd_q,        txd_d;
    logic                   word_ready_q, word_ready_d;

    logic [CHAR_W-1:0]      last_idx;
    logic [7:0]             next_char;

    // Nibble table indexed directly by character position: slot 0 holds the
    // most significant nibble. Slots past the last nibble are padded so the
    // table can be indexed by the full character index without range issues.
    logic [3:0] nibble_w [NIB_SLOTS];

    genvar gi;
    generate
        for (gi = 0; gi < NIB_SLOTS; gi++) begin : g_nibble
            if (gi < NIBBLES) begin : g_real
                assign nibble_w[gi] = data_q[DATA_WIDTH-1-4*gi -: 4];
            end else begin : g_pad
                assign nibble_w[gi] = 4'h0;
            end
        end
    endgenerate

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        // 'A' - 10 = 0x37
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    assign last_idx = eol_q ? IDX_LAST_E : IDX_LAST_H;

    // Character for the index the machine will hold next cycle; txd is a
    // registered output, so its next value is computed from next-state values.
    always_comb begin
        next_char = 8'h0A;
        if (char_idx_d < IDX_CR) begin
            next_char = hex_ascii(nibble_w[char_idx_d]);
        end else if (char_idx_d == IDX_CR) begin
            next_char = 8'h0D;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        data_d     = data_q;
        eol_d      = eol_q;

        case (state_q)
            IDLE: begin
                // word_ready is high whenever we are in IDLE
                if (word_valid) begin
                    data_d     = word_data;
                    eol_d      = word_eol;
                    char_idx_d = '0;
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = '0;
                    if (char_idx_q == last_idx) begin
                        state_d = IDLE;
                    end else begin
                        // next start bit follows the stop bit with no gap
                        char_idx_d = char_idx_q + CHAR_W'(1);
                        state_d    = START;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = next_char[bit_idx_d];
            default: txd_d = 1'b1;
        endcase

        word_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            char_idx_q   <= '0;
            data_q       <= '0;
            eol_q        <= 1'b0;
            txd_q        <= 1'b1;
            word_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            char_idx_q   <= char_idx_d;
            data_q       <= data_d;
            eol_q        <= eol_d;
            txd_q        <= txd_d;
            word_ready_q <= word_ready_d;
        end
    end

    assign txd        = txd_q;
    assign word_ready = word_ready_q;
    assign busy       = ~word_ready_q;

endmodule

// File: tb/tb_sdu_hex_tx.sv
// -----------------------------------------------------------------------------
// tb_sdu_hex_tx
//   Self-checking bench for sdu_hex_tx. Instance a uses CLKS_PER_BIT=4,
//   instance b uses CLKS_PER_BIT=868. Expected characters are pushed to a
//   per-instance queue when a word is driven; a UART receiver per instance
//   decodes txd and pops/compares each received character.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdu_hex_tx;

    logic        clk;
    logic        cpu_rst;

    logic        valid_a, ready_a, eol_a, txd_a, busy_a;
    logic [31:0] data_a;
    logic        valid_b, ready_b, eol_b, txd_b, busy_b;
    logic [31:0] data_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    sdu_hex_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(4)) u_dut_a (
        .cpu_clk    (clk),
        .cpu_rst    (cpu_rst),
        .word_valid (valid_a),
        .word_ready (ready_a),
        .word_data  (data_a),
        .word_eol   (eol_a),
        .txd        (txd_a),
        .busy       (busy_a)
    );

    sdu_hex_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(868)) u_dut_b (
        .cpu_clk    (clk),
        .cpu_rst    (cpu_rst),
        .word_valid (valid_b),
        .word_ready (ready_b),
        .word_data  (data_b),
        .word_eol   (eol_b),
        .txd        (txd_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic txd_of(input int u);
        return (u == 0) ? txd_a : txd_b;
    endfunction

    // Reference character stream for one word.
    function automatic void push_word(input int u, input logic [31:0] w, input logic eol);
        logic [3:0] nib;
        logic [7:0] ch;
        for (int i = 7; i >= 0; i--) begin
            nib = w[4*i +: 4];
            if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
            else             ch = 8'h41 + {4'h0, nib} - 8'd10;
            if (u == 0) exp_q_a.push_back(ch); else exp_q_b.push_back(ch);
        end
        if (eol) begin
            if (u == 0) begin exp_q_a.push_back(8'h0D); exp_q_a.push_back(8'h0A); end
            else        begin exp_q_b.push_back(8'h0D); exp_q_b.push_back(8'h0A); end
        end
    endfunction

    // UART receiver: every cycle of every bit is sampled; all samples of a bit
    // must agree. A reset seen mid-frame abandons the frame.
    task automatic uart_mon(input int u);
        int         cpb;
        logic [9:0] frame;
        logic       s, glitch, aborted;
        logic [8:0] expv;
        cpb = (u == 0) ? 4 : 868;
        forever begin
            @(negedge clk);
            if (txd_of(u) === 1'b0 && cpu_rst === 1'b0) begin
                glitch  = 1'b0;
                aborted = 1'b0;
                frame   = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < cpb && !aborted; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        s = txd_of(u);
                        if (cpu_rst === 1'b1) aborted = 1'b1;
                        else if (c == 0) frame[b] = s;
                        else if (s !== frame[b]) glitch = 1'b1;
                    end
                end
                if (aborted) begin
                    $display("rx[%0d] frame abandoned by reset", u);
                end else begin
                    if (u == 0) expv = (exp_q_a.size() != 0) ? {1'b0, exp_q_a.pop_front()} : 9'h100;
                    else        expv = (exp_q_b.size() != 0) ? {1'b0, exp_q_b.pop_front()} : 9'h100;
                    $display("rx[%0d] byte 0x%02h expected 0x%03h", u, frame[8:1], expv);
                    check_value("start_bit", {31'h0, frame[0]}, 32'h0);
                    check_value("stop_bit",  {31'h0, frame[9]}, 32'h1);
                    check_value("bit_stable", {31'h0, glitch}, 32'h0);
                    check_value("rx_byte", {23'h0, 1'b0, frame[8:1]}, {23'h0, expv});
                end
            end
        end
    endtask

    // Drive one word into instance a, check txd low right after acceptance,
    // and count busy cycles until the block is idle again.
    task automatic send_a(input logic [31:0] w, input logic eol, output int busy_cnt);
        push_word(0, w, eol);
        @(negedge clk);
        valid_a = 1'b1; data_a = w; eol_a = eol;
        @(posedge clk); #1;
        valid_a = 1'b0; data_a = 'x; eol_a = 1'b0;
        check_value("txd_low_after_accept", {31'h0, txd_a}, 32'h0);
        busy_cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b1) break;
            busy_cnt++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, t1, t2, lows;
        fork
            uart_mon(0);
            uart_mon(1);
        join_none

        cpu_rst = 1'b1;
        valid_a = 1'b0; data_a = 'x; eol_a = 1'b0;
        valid_b = 1'b0; data_b = 'x; eol_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_txd_a",   {31'h0, txd_a},   32'h1);
        check_value("rst_ready_a", {31'h0, ready_a}, 32'h1);
        check_value("rst_busy_a",  {31'h0, busy_a},  32'h0);
        check_value("rst_txd_b",   {31'h0, txd_b},   32'h1);
        @(negedge clk);
        cpu_rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: plain word
        $display("test1 word 0x1234ABCD eol=0");
        send_a(32'h1234ABCD, 1'b0, n);
        check_value("t1_busy_cycles", n, 320);
        repeat (3) @(negedge clk);
        check_value("t1_drained", exp_q_a.size(), 0);

        // 2: word with CR LF
        $display("test2 word 0x00000F9A eol=1");
        send_a(32'h00000F9A, 1'b1, n);
        check_value("t2_busy_cycles", n, 400);
        repeat (3) @(negedge clk);
        check_value("t2_drained", exp_q_a.size(), 0);

        // 3: back-to-back with valid held high
        $display("test3 back-to-back 0xFFFFFFFF then 0x00000000");
        push_word(0, 32'hFFFFFFFF, 1'b0);
        push_word(0, 32'h00000000, 1'b0);
        @(negedge clk);
        valid_a = 1'b1; data_a = 32'hFFFFFFFF; eol_a = 1'b0;
        @(posedge clk); #1;
        data_a = 32'h00000000;
        @(negedge clk);
        t1 = cyc;
        n = 1;
        for (int i = 0; i < 5000 && busy_a === 1'b1; i++) begin
            @(negedge clk);
            if (busy_a === 1'b1) n++;
        end
        check_value("t3_first_busy", n, 320);
        n = 0;
        for (int i = 0; i < 10 && ready_a === 1'b1; i++) begin
            n++;
            @(negedge clk);
        end
        valid_a = 1'b0; data_a = 'x;
        t2 = cyc;
        check_value("t3_ready_gap", n, 1);
        check_value("t3_start_spacing", t2 - t1, 321);
        check_value("t3_second_start_low", {31'h0, txd_a}, 32'h0);
        for (int i = 0; i < 5000 && busy_a === 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_value("t3_drained", exp_q_a.size(), 0);

        // 4: new requests while busy are ignored
        $display("test4 0x13579BDF with valid held during busy");
        push_word(0, 32'h13579BDF, 1'b0);
        @(negedge clk);
        valid_a = 1'b1; data_a = 32'h13579BDF;
        @(posedge clk); #1;
        data_a = 32'hAAAAAAAA; eol_a = 1'b1;
        bad = 0; n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b1) break;
            if (ready_a !== 1'b0) bad++;
            n++;
        end
        valid_a = 1'b0; data_a = 'x; eol_a = 1'b0;
        check_value("t4_ready_low_while_busy", bad, 0);
        check_value("t4_busy_cycles", n, 320);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd_a !== 1'b1) lows++;
        end
        check_value("t4_no_extra_chars", lows, 0);
        check_value("t4_drained", exp_q_a.size(), 0);

        // 5: reset in the middle of the third character
        $display("test5 reset during 0xDEADBEEF");
        push_word(0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        valid_a = 1'b1; data_a = 32'hDEADBEEF;
        @(posedge clk); #1;
        valid_a = 1'b0; data_a = 'x;
        repeat (94) @(negedge clk);
        check_value("t5_chars_before_reset", exp_q_a.size(), 6);
        cpu_rst = 1'b1;
        @(posedge clk); #1;
        check_value("t5_rst_txd", {31'h0, txd_a}, 32'h1);
        check_value("t5_rst_ready", {31'h0, ready_a}, 32'h1);
        exp_q_a.delete();
        repeat (2) @(negedge clk);
        cpu_rst = 1'b0;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd_a !== 1'b1) lows++;
        end
        check_value("t5_silent_after_reset", lows, 0);
        send_a(32'h00000001, 1'b0, n);
        check_value("t5_followup_busy", n, 320);
        repeat (3) @(negedge clk);
        check_value("t5_drained", exp_q_a.size(), 0);

        // 6: real baud divisor on instance b
        $display("test6 CLKS_PER_BIT=868 word 0x0000005A");
        push_word(1, 32'h0000005A, 1'b0);
        @(negedge clk);
        valid_b = 1'b1; data_b = 32'h0000005A; eol_b = 1'b0;
        @(posedge clk); #1;
        valid_b = 1'b0; data_b = 'x;
        check_value("t6_txd_low_after_accept", {31'h0, txd_b}, 32'h0);
        // '0' = 0x30: start bit plus data bits 0..3 are low -> 5 bit times
        lows = 0; n = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (txd_b !== 1'b0) break;
            lows++;
        end
        check_value("t6_low_run", lows, 5 * 868);
        n = lows;
        for (int i = 0; i < 80000 && busy_b === 1'b1; i++) begin
            n++;
            @(negedge clk);
        end
        check_value("t6_busy_cycles", n, 8 * 10 * 868);
        repeat (3) @(negedge clk);
        check_value("t6_drained", exp_q_b.size(), 0);
        check_value("t6_idle_a_drained", exp_q_a.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
